// File: rtl/pipeline_run_ctrl_if.sv
// Injection, fetch and retire signals between the run controller and its
// surroundings. The master side is the bench/core; the slave side is the controller.
interface pipeline_run_ctrl_if #(
  parameter int INSTR_W = 32
);
  logic               inj_valid;
  logic [INSTR_W-1:0] inj_instr;
  logic               inj_ready;
  logic [INSTR_W-1:0] imem_instr;
  logic [INSTR_W-1:0] fetch_instr;
  logic               fetch_from_inj;
  logic               retire_valid;
  logic [INSTR_W-1:0] retire_instr;

  modport master (
    output inj_valid, inj_instr, imem_instr, retire_valid, retire_instr,
    input  inj_ready, fetch_instr, fetch_from_inj
  );

  modport slave (
    input  inj_valid, inj_instr, imem_instr, retire_valid, retire_instr,
    output inj_ready, fetch_instr, fetch_from_inj
  );
endinterface

// File: rtl/pipeline_run_ctrl.sv
// Run controller: sequences core reset, runs the core for a bounded number of
// cycles, drains the pipeline and feeds injected instructions into fetch.
module pipeline_run_ctrl #(
  parameter int                 RESET_CYCLES = 2,
  parameter int                 MAX_CYCLES   = 8,
  parameter int                 PIPE_DEPTH   = 5,
  parameter int                 INJECT_DEPTH = 4,
  parameter int                 INSTR_W      = 32,
  parameter int                 CNT_W        = 32,
  parameter logic [INSTR_W-1:0] HALT_INSTR   = 32'hFFFF_FFFF,
  parameter logic [INSTR_W-1:0] NOP_INSTR    = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  pipeline_run_ctrl_if.slave     bus,
  output logic                   core_reset,
  output logic                   core_en,
  output logic                   busy,
  output logic                   halted,
  output logic [1:0]             done_reason,
  output logic [CNT_W-1:0]       cycle_count,
  output logic [CNT_W-1:0]       retire_count
);

  localparam int PTR_W  = $clog2(INJECT_DEPTH);
  localparam int OCC_W  = PTR_W + 1;
  localparam int PH_MAX = (RESET_CYCLES > PIPE_DEPTH) ? RESET_CYCLES : PIPE_DEPTH;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [PH_W-1:0]  RST_LOAD   = PH_W'(RESET_CYCLES - 1);
  localparam logic [PH_W-1:0]  DRAIN_LOAD = PH_W'(PIPE_DEPTH - 1);
  localparam logic [CNT_W-1:0] LIMIT_LAST = CNT_W'((MAX_CYCLES == 0) ? 0 : MAX_CYCLES - 1);
  localparam logic [OCC_W-1:0] OCC_FULL   = OCC_W'(INJECT_DEPTH);

  localparam logic [1:0] REASON_NONE  = 2'b00;
  localparam logic [1:0] REASON_LIMIT = 2'b01;
  localparam logic [1:0] REASON_HALT  = 2'b10;
  localparam logic [1:0] REASON_STOP  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RSTHOLD,
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  state_t             state_reg, state_next;
  logic [PH_W-1:0]    phase_reg, phase_next;
  logic [CNT_W-1:0]   cycle_count_reg, cycle_count_next;
  logic [CNT_W-1:0]   retire_count_reg, retire_count_next;
  logic [1:0]         reason_reg, reason_next;
  logic               core_reset_reg, core_en_reg, busy_reg, halted_reg;

  logic [INSTR_W-1:0] fifo_mem [INJECT_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [OCC_W-1:0]   occ_reg;
  logic               fifo_empty, push, pop;
  logic               halt_seen, limit_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign fifo_empty    = (occ_reg == '0);
  assign bus.inj_ready = (occ_reg < OCC_FULL);
  assign push          = bus.inj_valid && bus.inj_ready;
  assign pop           = (state_reg == ST_RUN) && !fifo_empty;
  assign halt_seen     = bus.retire_valid && (bus.retire_instr == HALT_INSTR);
  assign limit_hit     = (MAX_CYCLES != 0) && (cycle_count_reg == LIMIT_LAST);

  always_comb begin
    state_next        = state_reg;
    phase_next        = phase_reg;
    cycle_count_next  = cycle_count_reg;
    retire_count_next = retire_count_reg;
    reason_next       = reason_reg;

    case (state_reg)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          state_next        = ST_RSTHOLD;
          phase_next        = RST_LOAD;
          cycle_count_next  = '0;
          retire_count_next = '0;
          reason_next       = REASON_NONE;
        end
      end
      ST_RSTHOLD: begin
        if (phase_reg == '0) begin
          state_next = ST_RUN;
        end else begin
          phase_next = phase_reg - 1'b1;
        end
      end
      ST_RUN: begin
        cycle_count_next = sat_inc(cycle_count_reg);
        // Exit priority: stop, then halt retirement, then cycle budget.
        if (stop || halt_seen || limit_hit) begin
          state_next = ST_DRAIN;
          phase_next = DRAIN_LOAD;
          if (stop) begin
            reason_next = REASON_STOP;
          end else if (halt_seen) begin
            reason_next = REASON_HALT;
          end else begin
            reason_next = REASON_LIMIT;
          end
        end
      end
      ST_DRAIN: begin
        if (phase_reg == '0) begin
          state_next = ST_HALTED;
        end else begin
          phase_next = phase_reg - 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (((state_reg == ST_RUN) || (state_reg == ST_DRAIN)) && bus.retire_valid) begin
      retire_count_next = sat_inc(retire_count_reg);
    end
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      phase_reg        <= '0;
      cycle_count_reg  <= '0;
      retire_count_reg <= '0;
      reason_reg       <= REASON_NONE;
      core_reset_reg   <= 1'b1;
      core_en_reg      <= 1'b0;
      busy_reg         <= 1'b0;
      halted_reg       <= 1'b0;
    end else begin
      state_reg        <= state_next;
      phase_reg        <= phase_next;
      cycle_count_reg  <= cycle_count_next;
      retire_count_reg <= retire_count_next;
      reason_reg       <= reason_next;
      core_reset_reg   <= (state_next == ST_IDLE) || (state_next == ST_RSTHOLD);
      core_en_reg      <= (state_next == ST_RUN) || (state_next == ST_DRAIN);
      busy_reg         <= (state_next != ST_IDLE) && (state_next != ST_HALTED);
      halted_reg       <= (state_next == ST_HALTED);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ_reg <= occ_reg + 1'b1;
        2'b01:   occ_reg <= occ_reg - 1'b1;
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= bus.inj_instr;
    end
  end

  always_comb begin
    bus.fetch_instr    = bus.imem_instr;
    bus.fetch_from_inj = 1'b0;
    if (state_reg == ST_RUN && !fifo_empty) begin
      bus.fetch_instr    = fifo_mem[rd_ptr_reg];
      bus.fetch_from_inj = 1'b1;
    end else if (state_reg == ST_DRAIN) begin
      bus.fetch_instr    = NOP_INSTR;
    end
  end

  assign core_reset   = core_reset_reg;
  assign core_en      = core_en_reg;
  assign busy         = busy_reg;
  assign halted       = halted_reg;
  assign done_reason  = reason_reg;
  assign cycle_count  = cycle_count_reg;
  assign retire_count = retire_count_reg;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Bench for pipeline_run_ctrl: a cycle-limited and an unlimited instance share
// stimulus and are checked against a timeline-based reference model.
module tb_pipeline_run_ctrl;

  localparam int          R    = 2;
  localparam int          P    = 5;
  localparam int          D    = 4;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP  = 32'h0000_0000;

  typedef enum int {M_IDLE, M_RSTHOLD, M_RUN, M_DRAIN, M_HALTED} mphase_t;

  logic        clk = 1'b0;
  logic        reset, start, stop, inj_valid, retire_valid;
  logic [31:0] inj_instr, imem_instr, retire_instr;

  always #5 clk = ~clk;

  pipeline_run_ctrl_if #(.INSTR_W(32)) bus_a ();
  pipeline_run_ctrl_if #(.INSTR_W(32)) bus_b ();

  assign bus_a.inj_valid    = inj_valid;
  assign bus_a.inj_instr    = inj_instr;
  assign bus_a.imem_instr   = imem_instr;
  assign bus_a.retire_valid = retire_valid;
  assign bus_a.retire_instr = retire_instr;
  assign bus_b.inj_valid    = inj_valid;
  assign bus_b.inj_instr    = inj_instr;
  assign bus_b.imem_instr   = imem_instr;
  assign bus_b.retire_valid = retire_valid;
  assign bus_b.retire_instr = retire_instr;

  logic [1:0]  core_reset_w, core_en_w, busy_w, halted_w, ready_w, from_inj_w;
  logic [1:0]  reason_w [2];
  logic [31:0] cyc_w [2];
  logic [31:0] ret_w [2];
  logic [31:0] fetch_w [2];

  assign ready_w[0]    = bus_a.inj_ready;
  assign ready_w[1]    = bus_b.inj_ready;
  assign from_inj_w[0] = bus_a.fetch_from_inj;
  assign from_inj_w[1] = bus_b.fetch_from_inj;
  assign fetch_w[0]    = bus_a.fetch_instr;
  assign fetch_w[1]    = bus_b.fetch_instr;

  pipeline_run_ctrl #(.MAX_CYCLES(8)) u_dut_lim (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .bus(bus_a),
    .core_reset(core_reset_w[0]), .core_en(core_en_w[0]), .busy(busy_w[0]),
    .halted(halted_w[0]), .done_reason(reason_w[0]), .cycle_count(cyc_w[0]),
    .retire_count(ret_w[0])
  );

  pipeline_run_ctrl #(.MAX_CYCLES(0)) u_dut_unl (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .bus(bus_b),
    .core_reset(core_reset_w[1]), .core_en(core_en_w[1]), .busy(busy_w[1]),
    .halted(halted_w[1]), .done_reason(reason_w[1]), .cycle_count(cyc_w[1]),
    .retire_count(ret_w[1])
  );

  // Reference model: a run is a timeline measured in cycles since start.
  bit          m_active [2];
  bit          m_halted [2];
  int          m_age [2];
  int          m_run_len [2];
  int          m_cycles [2];
  int          m_retires [2];
  logic [1:0]  m_reason [2];
  logic [31:0] mq [2][$];

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  function automatic int max_cycles(int k);
    return (k == 0) ? 8 : 0;
  endfunction

  function automatic mphase_t phase_of(int k);
    if (!m_active[k]) return m_halted[k] ? M_HALTED : M_IDLE;
    if (m_age[k] < R) return M_RSTHOLD;
    if (m_run_len[k] < 0) return M_RUN;
    return M_DRAIN;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      mphase_t     ph;
      logic [31:0] exp_fetch;
      logic        exp_inj;
      ph        = phase_of(k);
      exp_fetch = imem_instr;
      exp_inj   = 1'b0;
      if (ph == M_RUN && mq[k].size() > 0) begin
        exp_fetch = mq[k][0];
        exp_inj   = 1'b1;
      end else if (ph == M_DRAIN) begin
        exp_fetch = NOP;
      end
      chk($sformatf("core_reset[%0d]", k), core_reset_w[k], (ph == M_IDLE || ph == M_RSTHOLD));
      chk($sformatf("core_en[%0d]", k), core_en_w[k], (ph == M_RUN || ph == M_DRAIN));
      chk($sformatf("busy[%0d]", k), busy_w[k], (ph != M_IDLE && ph != M_HALTED));
      chk($sformatf("halted[%0d]", k), halted_w[k], (ph == M_HALTED));
      chk($sformatf("reason[%0d]", k), reason_w[k], m_reason[k]);
      chk($sformatf("cycle_count[%0d]", k), cyc_w[k], m_cycles[k]);
      chk($sformatf("retire_count[%0d]", k), ret_w[k], m_retires[k]);
      chk($sformatf("inj_ready[%0d]", k), ready_w[k], (mq[k].size() < D));
      chk($sformatf("fetch_instr[%0d]", k), fetch_w[k], exp_fetch);
      chk($sformatf("fetch_from_inj[%0d]", k), from_inj_w[k], exp_inj);
    end
  endtask

  task automatic update_model();
    for (int k = 0; k < 2; k++) begin
      mphase_t ph;
      bit      can_push;
      ph = phase_of(k);
      if (reset) begin
        mq[k].delete();
        m_active[k]  = 1'b0;
        m_halted[k]  = 1'b0;
        m_age[k]     = 0;
        m_run_len[k] = -1;
        m_cycles[k]  = 0;
        m_retires[k] = 0;
        m_reason[k]  = 2'b00;
      end else begin
        can_push = inj_valid && (mq[k].size() < D);
        if (ph == M_RUN && mq[k].size() > 0) void'(mq[k].pop_front());
        if (can_push) mq[k].push_back(inj_instr);
        if ((ph == M_RUN || ph == M_DRAIN) && retire_valid) m_retires[k]++;
        if (ph == M_RUN) begin
          m_cycles[k]++;
          if (stop) begin
            m_reason[k] = 2'b11; m_run_len[k] = m_cycles[k];
          end else if (retire_valid && retire_instr == HALT) begin
            m_reason[k] = 2'b10; m_run_len[k] = m_cycles[k];
          end else if (max_cycles(k) != 0 && m_cycles[k] == max_cycles(k)) begin
            m_reason[k] = 2'b01; m_run_len[k] = m_cycles[k];
          end
        end
        if (m_active[k]) begin
          m_age[k]++;
          if (m_run_len[k] >= 0 && m_age[k] >= R + m_run_len[k] + P) begin
            m_active[k] = 1'b0;
            m_halted[k] = 1'b1;
          end
        end
        if ((ph == M_IDLE || ph == M_HALTED) && start) begin
          m_active[k]  = 1'b1;
          m_halted[k]  = 1'b0;
          m_age[k]     = 0;
          m_run_len[k] = -1;
          m_cycles[k]  = 0;
          m_retires[k] = 0;
          m_reason[k]  = 2'b00;
        end
      end
    end
  endtask

  task automatic idle_inputs();
    start        = 1'b0;
    stop         = 1'b0;
    inj_valid    = 1'b0;
    inj_instr    = $urandom;
    retire_valid = 1'b0;
    retire_instr = $urandom_range(32'h7FFF_FFFF);
    imem_instr   = $urandom;
  endtask

  // Entered at a falling edge with inputs set; leaves at the next falling edge.
  task automatic step();
    #1;
    if (check_en) check_all();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  task automatic run_steps(input int n);
    for (int i = 0; i < n; i++) begin
      idle_inputs();
      step();
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic do_start();
    idle_inputs();
    start = 1'b1;
    step();
  endtask

  task automatic push_word(input logic [31:0] w);
    idle_inputs();
    inj_valid = 1'b1;
    inj_instr = w;
    step();
  endtask

  initial begin
    logic [31:0] words [5];
    words = '{32'hA000_000A, 32'hB000_000B, 32'hC000_000C, 32'hD000_000D, 32'hE000_000E};
    for (int k = 0; k < 2; k++) begin
      m_active[k] = 1'b0; m_halted[k] = 1'b0; m_age[k] = 0; m_run_len[k] = -1;
      m_cycles[k] = 0; m_retires[k] = 0; m_reason[k] = 2'b00;
    end
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    step();
    check_en = 1'b1;
    step();
    reset = 1'b0;

    // Default limited run; start at cycle 3.
    run_steps(2);
    do_start();
    run_steps(15);
    chk("limit_halted", halted_w[0], 1'b1);
    chk("limit_cycles", cyc_w[0], 32'd8);
    chk("limit_reason", reason_w[0], 2'b01);

    // Unlimited instance keeps running: halt retired in its RUN cycle 20.
    for (int i = 0; i < 40 && phase_of(1) == M_RUN; i++) begin
      idle_inputs();
      if (m_age[1] - R + 1 == 20) begin
        retire_valid = 1'b1;
        retire_instr = HALT;
      end
      step();
    end
    chk("halt20_reason", reason_w[1], 2'b10);
    chk("halt20_cycles", cyc_w[1], 32'd20);
    chk("halt20_retires", ret_w[1], 32'd1);

    // Preload four words, fifth dropped, then fetch them in order.
    do_reset();
    for (int i = 0; i < 4; i++) push_word(words[i]);
    chk("full_ready", ready_w[0], 1'b0);
    push_word(words[4]);
    do_start();
    run_steps(2);
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      #1;
      chk($sformatf("preload_fetch%0d", i), fetch_w[0], words[i]);
      step();
    end
    idle_inputs();
    #1;
    chk("after_preload_inj", from_inj_w[0], 1'b0);
    chk("after_preload_fetch", fetch_w[0], imem_instr);
    step();

    // Stop and halt in the same RUN cycle 3: stop wins.
    do_reset();
    do_start();
    run_steps(4);
    idle_inputs();
    stop         = 1'b1;
    retire_valid = 1'b1;
    retire_instr = HALT;
    step();
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      #1;
      chk($sformatf("drain_nop%0d", i), fetch_w[0], NOP);
      step();
    end
    chk("stop_reason", reason_w[0], 2'b11);
    chk("stop_cycles", cyc_w[0], 32'd3);

    // Push and pop in the same cycle at occupancy 2, then reset during DRAIN.
    do_reset();
    push_word(words[0]);
    push_word(words[1]);
    do_start();
    run_steps(2);
    push_word(words[2]);
    chk("pushpop_fetch", fetch_w[0], words[1]);
    chk("pushpop_inj", from_inj_w[0], 1'b1);
    for (int i = 0; i < 20 && phase_of(0) != M_DRAIN; i++) run_steps(1);
    chk("reached_drain", busy_w[0] && core_en_w[0] && (fetch_w[0] == NOP), 1'b1);
    run_steps(2);
    do_reset();
    chk("rst_drain_cycles", cyc_w[0], 32'd0);
    chk("rst_drain_core_reset", core_reset_w[0], 1'b1);
    chk("rst_drain_ready", ready_w[0], 1'b1);
    chk("rst_drain_busy", busy_w[0], 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      idle_inputs();
      reset        = ($urandom_range(199) == 0);
      start        = ($urandom_range(19) == 0);
      stop         = ($urandom_range(29) == 0);
      retire_valid = $urandom_range(1);
      if ($urandom_range(15) == 0) retire_instr = HALT;
      inj_valid    = ($urandom_range(2) == 0);
      step();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_run_ctrl.md
# pipeline_run_ctrl

Synthesisable run controller that sits between the bench/top level and the pipelined core. It sequences core reset, enables the core for a bounded number of cycles, and drains the pipeline on completion. It injects directed instructions into fetch from a small FIFO and reports cycle/retire counts and a termination reason. It replaces free-running clock-count and hand-poked instruction stimulus with a parametrised, self-terminating block.

## Interface
- RESET_CYCLES, 2: cycles `core_reset` is held high after `start` (≥1).
- MAX_CYCLES, 8: RUN-state cycle budget; 0 = unlimited.
- PIPE_DEPTH, 5: drain cycles after RUN ends (≥1).
- INJECT_DEPTH, 4: injection FIFO entries (power of two, ≥2).
- INSTR_W, 32: instruction width.
- CNT_W, 32: counter width.
- HALT_INSTR, 32'hFFFF_FFFF: retired encoding that ends the run.
- NOP_INSTR, 32'h0000_0000: encoding fed to fetch during drain.

Ports:
- clk  in  1  clock; all logic rising-edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- start  in  1  pulse; begins a run from IDLE or HALTED.
- stop  in  1  pulse; aborts RUN into DRAIN.
- inj_valid  in  1  injection push request.
- inj_instr  in  INSTR_W  instruction to push.
- inj_ready  out  1  FIFO not full.
- imem_instr  in  INSTR_W  instruction from instruction memory.
- fetch_instr  out  INSTR_W  instruction presented to core fetch.
- fetch_from_inj  out  1  `fetch_instr` sourced from FIFO this cycle.
- retire_valid  in  1  core retired an instruction.
- retire_instr  in  INSTR_W  retired encoding.
- core_reset  out  1  reset to core.
- core_en  out  1  core clock-enable.
- busy  out  1  state ≠ IDLE and ≠ HALTED.
- halted  out  1  state = HALTED.
- done_reason  out  2  00 none, 01 cycle limit, 10 halt instruction, 11 stop.
- cycle_count  out  CNT_W  RUN cycles elapsed.
- retire_count  out  CNT_W  retirements counted.

## Operation
- States: IDLE, RSTHOLD, RUN, DRAIN, HALTED.
- IDLE/HALTED + start → RSTHOLD; clears cycle_count, retire_count, done_reason; does not flush FIFO (preload allowed).
- RSTHOLD: core_reset=1, core_en=0 for exactly RESET_CYCLES cycles → RUN.
- RUN: core_en=1, core_reset=0; cycle_count += 1 per cycle. Exit to DRAIN on first of, priority stop > halt > limit:
  - stop=1 → reason 11.
  - retire_valid && retire_instr==HALT_INSTR → reason 10.
  - MAX_CYCLES≠0 and the cycle in which cycle_count becomes MAX_CYCLES → reason 01.
- DRAIN: core_en=1, fetch_instr=NOP_INSTR, FIFO not popped, for PIPE_DEPTH cycles → HALTED. Halt/stop in DRAIN ignored.
- HALTED: core_en=0, core_reset=0; counts/reason held.
- start while busy: ignored. stop outside RUN: ignored.
- Fetch mux, RUN only: FIFO non-empty → fetch_instr=FIFO head, fetch_from_inj=1, pop this cycle; else fetch_instr=imem_instr. Outside RUN/DRAIN: fetch_instr=imem_instr, fetch_from_inj=0.
- FIFO: push when inj_valid && inj_ready in any state; simultaneous push+pop keeps occupancy; inj_ready = occupancy < INJECT_DEPTH; pushes while full dropped (bench violation). Pointers wrap modulo INJECT_DEPTH.
- retire_count += 1 per retire_valid cycle while core_en=1 (RUN or DRAIN), including the halt instruction.
- Counters saturate at all-ones; no wrap.

## Timing
- Reset values: state IDLE, core_reset=1, core_en=0, busy=0, halted=0, done_reason=00, counts=0, FIFO empty, inj_ready=1, fetch_from_inj=0.
- core_reset/core_en/busy/halted/done_reason registered; fetch mux and inj_ready combinational from registered state/occupancy.
- IDLE: core_reset stays 1. Start at edge N: RSTHOLD from N+1; RUN from N+1+RESET_CYCLES.
- Exit condition sampled in RUN cycle k: that cycle counted; DRAIN next cycle; done_reason valid from first DRAIN cycle.
- reset mid-run: next edge forces all reset values, FIFO flushed, in-flight counts lost.
- Default run: start → 2 RSTHOLD + 8 RUN + 5 DRAIN → HALTED.

## Test plan
- Defaults, start at cycle 3, no injection → core_reset high until RUN; cycle_count=8, done_reason=01, halted asserted 15 cycles after start edge.
- Preload 4 words (A,B,C,D) in IDLE, inj_ready drops after 4th; start → first 4 RUN cycles fetch A–D, fetch_from_inj=1, then imem_instr.
- retire 32'hFFFF_FFFF in RUN cycle 3 with stop same cycle → done_reason=11, cycle_count=3, DRAIN fetches NOP_INSTR for 5 cycles.
- MAX_CYCLES=0, retire HALT_INSTR at RUN cycle 20 → reason 10, cycle_count=20, retire_count includes halt.
- Push+pop same cycle at occupancy 2 → occupancy stays 2; 5th push while full dropped.
- reset asserted in DRAIN → next cycle IDLE, counts 0, FIFO empty, core_reset=1.
